// File: rtl/fx3_slave_fifo_responder_pkg.sv
// Shared constants for the FX3 slave-FIFO responder.
// - socket addresses on the GPIF ADDR lines
// - default bus/socket word width
// - bit positions of FLAGA..FLAGD inside the packed flag register
package fx3_sf_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] ADDR_RD_SOCK = 2'b11;  // FX3 -> FPGA
  localparam logic [1:0] ADDR_WR_SOCK = 2'b00;  // FPGA -> FX3

  localparam int FLAG_A = 0;  // write socket not full
  localparam int FLAG_B = 1;  // write socket free words > WM
  localparam int FLAG_C = 2;  // read socket not empty
  localparam int FLAG_D = 3;  // read socket words > WM
  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/fx3_slave_fifo_responder_if.sv
// GPIF II slave-FIFO bus bundle between an FPGA master and the FX3 responder.
// Ports (master view):
//   slcs_n, sloe_n, slrd_n, slwr_n, pkend_n, addr, dq_i  master -> FX3
//   dq_o, dq_oe, flaga..flagd                             FX3 -> master
interface fx3_slave_fifo_responder_if
  import fx3_sf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              slcs_n;
  logic              sloe_n;
  logic              slrd_n;
  logic              slwr_n;
  logic              pkend_n;
  logic [1:0]        addr;
  logic [DATA_W-1:0] dq_i;
  logic [DATA_W-1:0] dq_o;
  logic              dq_oe;
  logic              flaga;
  logic              flagb;
  logic              flagc;
  logic              flagd;

  modport master (
    output slcs_n, sloe_n, slrd_n, slwr_n, pkend_n, addr, dq_i,
    input  dq_o, dq_oe, flaga, flagb, flagc, flagd
  );

  modport slave (
    input  slcs_n, sloe_n, slrd_n, slwr_n, pkend_n, addr, dq_i,
    output dq_o, dq_oe, flaga, flagb, flagc, flagd
  );
endinterface

// File: rtl/fx3_slave_fifo_responder_fifo.sv
// Synchronous FIFO used as one FX3 socket buffer.
// Ports:
//   clk_pll, reset      clock, synchronous active-high reset
//   push, push_data     write request; ignored while full
//   pop                 read request; ignored while empty
//   pop_data            head word (combinational, valid while !empty)
//   count, full, empty  occupancy
// A push and a pop in the same cycle both take effect and leave count unchanged.
module sf_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_pll,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage carries no reset: stale words are unreachable once pointers clear.
  always_ff @(posedge clk_pll) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// FX3 side of the GPIF II slave-FIFO interface, used as a board-less stand-in
// for loopback testing of an FPGA slave-FIFO master.
// Ports:
//   clk_pll, reset        single clock, synchronous active-high reset
//   bus (slave modport)   GPIF strobes/address/data in, dq_o/dq_oe/flags out
//   src_valid/data/ready  host stream filling the read socket (ADDR 2'b11)
//   snk_valid/data/ready  host stream draining the write socket (ADDR 2'b00)
//   pkt_cnt               committed packet count, wraps
//   ovf_err, unf_err      sticky write-overflow / read-underflow
module fx3_slave_fifo_responder
  import fx3_sf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 64,
  parameter int WM     = 4,
  parameter int RD_LAT = 2
) (
  input  logic                         clk_pll,
  input  logic                         reset,
  fx3_slave_fifo_responder_if.slave    bus,
  input  logic                         src_valid,
  input  logic [DATA_W-1:0]            src_data,
  output logic                         src_ready,
  output logic                         snk_valid,
  output logic [DATA_W-1:0]            snk_data,
  input  logic                         snk_ready,
  output logic [15:0]                  pkt_cnt,
  output logic                         ovf_err,
  output logic                         unf_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_WM    = CW'(WM);

  logic sel, rd, wr, pkend, oe_req;

  assign sel    = ~bus.slcs_n;
  assign rd     = sel & ~bus.slrd_n  & (bus.addr == ADDR_RD_SOCK);
  assign wr     = sel & ~bus.slwr_n  & (bus.addr == ADDR_WR_SOCK);
  assign pkend  = sel & ~bus.pkend_n & (bus.addr == ADDR_WR_SOCK);
  assign oe_req = sel & ~bus.sloe_n  & (bus.addr == ADDR_RD_SOCK);

  logic [DATA_W-1:0] rd_head;
  logic [CW-1:0]     rd_cnt;
  logic              rd_full, rd_empty, rd_pop_ok;

  logic [CW-1:0]     wr_cnt;
  logic              wr_full, wr_empty;

  assign src_ready = ~rd_full;
  assign rd_pop_ok = rd & ~rd_empty;
  assign snk_valid = ~wr_empty;

  sf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_sock (
    .clk_pll   (clk_pll),
    .reset     (reset),
    .push      (src_valid),
    .push_data (src_data),
    .pop       (rd),
    .pop_data  (rd_head),
    .count     (rd_cnt),
    .full      (rd_full),
    .empty     (rd_empty)
  );

  sf_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_wr_sock (
    .clk_pll   (clk_pll),
    .reset     (reset),
    .push      (wr),
    .push_data (bus.dq_i),
    .pop       (snk_ready),
    .pop_data  (snk_data),
    .count     (wr_cnt),
    .full      (wr_full),
    .empty     (wr_empty)
  );

  // Read return path: slot 0 is loaded on the popping edge, dq_o takes the
  // last slot RD_LAT edges later. Invalid slots (underflow, idle) leave dq_o alone.
  logic [RD_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0] pipe_dat [RD_LAT];
  logic [DATA_W-1:0] dq_q;
  logic              dq_oe_q;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [15:0]       pkt_q;
  logic              ovf_q, unf_q;

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_dat[i] <= '0;
      dq_q     <= '0;
      dq_oe_q  <= 1'b0;
      flags_q  <= '0;
      pkt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_pop_ok;
      pipe_dat[0] <= rd_head;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
      if (pipe_vld[RD_LAT-1]) dq_q <= pipe_dat[RD_LAT-1];

      dq_oe_q <= oe_req;

      // Flags follow the count registers by one edge; the master's WM must
      // absorb the strobes it issues before it sees the change.
      flags_q[FLAG_A] <= (wr_cnt < CNT_DEPTH);
      flags_q[FLAG_B] <= ((CNT_DEPTH - wr_cnt) > CNT_WM);
      flags_q[FLAG_C] <= (rd_cnt != '0);
      flags_q[FLAG_D] <= (rd_cnt > CNT_WM);

      // A lone pkend (no wr) is a zero-length packet and still commits one.
      if (pkend) pkt_q <= pkt_q + 16'd1;

      if (wr & wr_full)  ovf_q <= 1'b1;
      if (rd & rd_empty) unf_q <= 1'b1;
    end
  end

  assign bus.dq_o  = dq_q;
  assign bus.dq_oe = dq_oe_q;
  assign bus.flaga = flags_q[FLAG_A];
  assign bus.flagb = flags_q[FLAG_B];
  assign bus.flagc = flags_q[FLAG_C];
  assign bus.flagd = flags_q[FLAG_D];
  assign pkt_cnt   = pkt_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// Bench for fx3_slave_fifo_responder (DATA_W=32, DEPTH=64, WM=4, RD_LAT=2).
// Read data and host-sink words are checked by a monitor against queues filled
// when stimulus is issued; flags, counters and error bits are checked inline.
module tb_fx3_slave_fifo_responder;
  import fx3_sf_pkg::*;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic        snk_valid;
  logic [31:0] snk_data;
  logic        snk_ready;
  logic [15:0] pkt_cnt;
  logic        ovf_err;
  logic        unf_err;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [31:0] snk_q[$];

  fx3_slave_fifo_responder_if bus ();

  fx3_slave_fifo_responder dut (
    .clk_pll   (clk_pll),
    .reset     (reset),
    .bus       (bus),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .snk_valid (snk_valid),
    .snk_data  (snk_data),
    .snk_ready (snk_ready),
    .pkt_cnt   (pkt_cnt),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err)
  );

  always #5 clk_pll = ~clk_pll;
  always @(posedge clk_pll) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whenever the DUT presents a read word or a sink handshake.
  always @(negedge clk_pll) begin
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      check("dq_o", bus.dq_o, rd_q[0].data);
      void'(rd_q.pop_front());
    end
    if (snk_valid === 1'b1 && snk_ready === 1'b1) begin
      if (snk_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL snk_extra: got %h expected no word", snk_data);
      end else begin
        check("snk_data", snk_data, snk_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_idle();
    bus.slcs_n  = 1'b1;
    bus.sloe_n  = 1'b1;
    bus.slrd_n  = 1'b1;
    bus.slwr_n  = 1'b1;
    bus.pkend_n = 1'b1;
    bus.addr    = ADDR_WR_SOCK;
  endtask

  task automatic load_src(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      src_valid = 1'b1;
      src_data  = base + 32'(i);
      tick();
    end
    src_valid = 1'b0;
  endtask

  // A rd sampled at the next edge (cyc+1) reaches dq_o two edges later (cyc+3).
  task automatic bus_read(input int n, input logic [31:0] base, input bit expect_data);
    bus.slcs_n = 1'b0;
    bus.sloe_n = 1'b0;
    bus.addr   = ADDR_RD_SOCK;
    bus.slrd_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (expect_data) rd_q.push_back('{cyc + 3, base + 32'(i)});
      tick();
    end
    bus.slrd_n = 1'b1;
  endtask

  task automatic bus_write(input logic [31:0] data, input bit pkend, input bit expect_word);
    bus.slcs_n  = 1'b0;
    bus.addr    = ADDR_WR_SOCK;
    bus.slwr_n  = 1'b0;
    bus.pkend_n = ~pkend;
    bus.dq_i    = data;
    if (expect_word) snk_q.push_back(data);
    tick();
    bus.slwr_n  = 1'b1;
    bus.pkend_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((rd_q.size() != 0 || snk_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (rd_q.size() != 0 || snk_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s: %0d rd and %0d snk words outstanding, expected 0", name, rd_q.size(), snk_q.size());
    end
  endtask

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    snk_ready = 1'b0;
    bus.dq_i  = '0;
    bus_idle();
    ticks(3);
    check("rst_flaga", bus.flaga, 0);
    check("rst_flagb", bus.flagb, 0);
    check("rst_flagc", bus.flagc, 0);
    check("rst_dq_o", bus.dq_o, 0);
    check("rst_dq_oe", bus.dq_oe, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_errs", {ovf_err, unf_err}, 0);
    reset = 1'b0;
    tick();
    check("idle_flaga", bus.flaga, 1);
    check("idle_flagb", bus.flagb, 1);
    check("idle_flagc", bus.flagc, 0);
    check("idle_src_ready", src_ready, 1);

    // 8 words through the read socket
    load_src(32'h1, 8);
    tick();
    check("load8_flagc", bus.flagc, 1);
    check("load8_flagd", bus.flagd, 1);
    bus_read(8, 32'h1, 1'b1);
    check("rd_dq_oe", bus.dq_oe, 1);
    check("pop8_flagc_lag", bus.flagc, 1);
    tick();
    check("pop8_flagc", bus.flagc, 0);
    bus_idle();

    // watermark on the read socket
    load_src(32'h11, 6);
    tick();
    check("load6_flagd", bus.flagd, 1);
    bus_read(2, 32'h11, 1'b1);
    check("pop2_flagd_lag", bus.flagd, 1);
    tick();
    check("pop2_flagd", bus.flagd, 0);
    check("pop2_flagc", bus.flagc, 1);
    bus_read(4, 32'h13, 1'b1);
    bus_idle();
    ticks(4);

    // bus writes with the host holding off, then fill to full
    for (int i = 0; i < 3; i++) bus_write(32'hA5A5_0000 + 32'(i), 1'b0, 1'b1);
    tick();
    check("wr3_snk_valid", snk_valid, 1);
    check("wr3_snk_head", snk_data, 32'hA5A5_0000);
    check("wr3_flagb", bus.flagb, 1);
    w = 32'hB000_0000;
    for (int i = 0; i < 56; i++) begin
      bus_write(w, 1'b0, 1'b1);
      w = w + 1;
    end
    tick();
    check("free5_flagb", bus.flagb, 1);
    bus_write(w, 1'b0, 1'b1);
    w = w + 1;
    tick();
    check("free4_flagb", bus.flagb, 0);
    check("free4_flaga", bus.flaga, 1);
    for (int i = 0; i < 4; i++) begin
      bus_write(w, 1'b0, 1'b1);
      w = w + 1;
    end
    tick();
    check("full_flaga", bus.flaga, 0);
    check("full_ovf_pre", ovf_err, 0);
    bus_write(32'hDEAD_BEEF, 1'b0, 1'b0);
    check("ovf_err", ovf_err, 1);
    bus_idle();
    snk_ready = 1'b1;
    wait_drain("drain_full");
    ticks(2);
    check("drained_snk_valid", snk_valid, 0);
    check("drained_flaga", bus.flaga, 1);
    snk_ready = 1'b0;

    // underflow on the empty read socket
    bus_read(1, 32'h0, 1'b0);
    check("unf_err", unf_err, 1);
    ticks(4);
    check("unf_dq_hold", bus.dq_o, 32'h16);
    bus_idle();

    // reset while a popped word is still in the read pipeline
    load_src(32'h21, 3);
    tick();
    bus_read(1, 32'h0, 1'b0);
    reset = 1'b1;
    bus_idle();
    tick();
    reset = 1'b0;
    check("mid_rst_flags", {bus.flaga, bus.flagb, bus.flagc, bus.flagd}, 0);
    check("mid_rst_errs", {ovf_err, unf_err}, 0);
    check("mid_rst_dq_o", bus.dq_o, 0);
    tick();
    load_src(32'h31, 1);
    tick();
    bus_read(1, 32'h31, 1'b1);
    bus_idle();
    ticks(4);
    check("after_rst_flagc", bus.flagc, 0);

    // packet end with word 4, then a zero-length packet
    bus_write(32'h41, 1'b0, 1'b1);
    bus_write(32'h42, 1'b0, 1'b1);
    bus_write(32'h43, 1'b0, 1'b1);
    bus_write(32'h44, 1'b1, 1'b1);
    bus.pkend_n = 1'b0;
    tick();
    bus.pkend_n = 1'b1;
    tick();
    check("pkt_cnt_2", pkt_cnt, 2);

    // strobes on an unused socket address change nothing
    bus.slcs_n  = 1'b0;
    bus.addr    = 2'b01;
    bus.slwr_n  = 1'b0;
    bus.slrd_n  = 1'b0;
    bus.pkend_n = 1'b0;
    bus.dq_i    = 32'hBAD0_0001;
    ticks(3);
    bus_idle();
    tick();
    check("addr01_pkt_cnt", pkt_cnt, 2);
    check("addr01_errs", {ovf_err, unf_err}, 0);
    check("addr01_dq_o", bus.dq_o, 32'h31);
    snk_ready = 1'b1;
    wait_drain("drain_pkt");
    ticks(2);
    check("pkt_drained_snk_valid", snk_valid, 0);
    snk_ready = 1'b0;

    wait_drain("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
